rng_stream: RTL



---
 rtl/rng_pkg.sv | 33 +++
 rtl/rng_lfsr.sv | 47 ++++
 rtl/rng_stream.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_pkg
// Description : Shared types and constants for the rng_stream generator:
//               FSM state encoding, default Galois tap masks for common
//               widths, and a helper that checks a constant fits in W bits.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

  // Generator phase: WARM discards steps, RUN feeds the output stage.
  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Maximal-length Galois feedback masks (right-shifting form).
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;

  localparam int W_MIN = 8;
  localparam int W_MAX = 32;

  // True when 'value' has no bits set above bit w-1.
  function automatic logic fits_width(input logic [31:0] value, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (value & ~mask) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rng_lfsr
// Description : W-bit right-shifting Galois LFSR with step enable and a
//               parallel load port. Load wins over step. A zero load value
//               is replaced by all ones so the register can never lock up.
// Ports       : clk, reset (sync, active-high, resets to all ones)
//               step       - advance one state
//               load       - load load_value (zero becomes all ones)
//               load_value - W-bit value to load
//               value      - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module rng_lfsr
  import rng_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(TAPS_16)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value
);

  logic [W-1:0] lfsr_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_state <= '1;
    end else if (load) begin
      lfsr_state <= (load_value == '0) ? '1 : load_value;
    end else if (step) begin
      if (lfsr_state[0]) begin
        lfsr_state <= (lfsr_state >> 1) ^ TAPS;
      end else begin
        lfsr_state <= lfsr_state >> 1;
      end
    end
  end

  assign value = lfsr_state;

endmodule
`default_nettype wire

// File: rtl/rng_stream.sv
`default_nettype none
// ============================================================================
// Module      : rng_stream
// Description : Parametrised pseudo-random word source. Output word is a
//               rotate-right seed register XORed with a Galois LFSR. Supports
//               runtime reseed, a warm-up phase and a valid/ready output
//               stage. Under backpressure the generator keeps stepping and
//               the skipped values are dropped.
// Config      : define RNG_HEALTH_EN to build the repetition health test;
//               without it health_err is tied low.
// Ports       : clk, reset (sync, active-high)
//               seed_valid/seed_ready/seed_i - reseed handshake
//               rng_valid/rng_ready/rng_o    - output word handshake
//               health_err                   - sticky repetition failure
// Revision    : 1.0 - initial release
// ============================================================================
module rng_stream
  import rng_pkg::*;
#(
  parameter int          W         = 16,
  parameter logic [31:0] SEED      = 32'h0000_A5A5,
  parameter logic [31:0] TAPS      = 32'h0000_B400,
  parameter int          WARMUP    = 16,
  parameter int          REP_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seed_valid,
  input  logic [W-1:0] seed_i,
  output logic         seed_ready,
  output logic         rng_valid,
  input  logic         rng_ready,
  output logic [W-1:0] rng_o,
  output logic         health_err
);

  localparam logic [W-1:0] SEED_W      = SEED[W-1:0];
  localparam logic [W-1:0] TAPS_W      = TAPS[W-1:0];
  localparam int           CW          = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WARMUP_C   = CW'(WARMUP);
  localparam state_t       START_STATE = (WARMUP == 0) ? RUN : WARM;

  generate
    if (W < W_MIN || W > W_MAX || !fits_width(TAPS, W)) begin : g_param_check
      $error("rng_stream: W must be 8..32 and TAPS must fit in W bits");
    end
  endgenerate

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   warm_cnt;
  logic [W-1:0]    rotor;
  logic [W-1:0]    lfsr_value;
  logic            seed_accept;
  logic            gen_step;
  logic            load_word;

  assign seed_accept = seed_valid && seed_ready;

  // --------------------------------------------------------------------------
  // Galois LFSR
  // --------------------------------------------------------------------------
  rng_lfsr #(
    .W    (W),
    .TAPS (TAPS_W)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step       (gen_step),
    .load       (seed_accept),
    .load_value (seed_i),
    .value      (lfsr_value)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= START_STATE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (seed_accept) begin
      state_next = START_STATE;
    end else if (state == WARM && warm_cnt == CW'(1)) begin
      state_next = RUN;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    gen_step  = 1'b0;
    load_word = 1'b0;
    case (state)
      WARM: begin
        gen_step = 1'b1;
      end
      RUN: begin
        gen_step  = 1'b1;
        load_word = !rng_valid || rng_ready;
      end
      default: begin
        gen_step  = 1'b0;
        load_word = 1'b0;
      end
    endcase
  end

  // Warm-up counter: reloaded on reset and reseed, counts down in WARM.
  always_ff @(posedge clk) begin
    if (reset || seed_accept) begin
      warm_cnt <= WARMUP_C;
    end else if (state == WARM && warm_cnt != '0) begin
      warm_cnt <= warm_cnt - CW'(1);
    end
  end

  // Reseed is only accepted once the block is out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_ready <= 1'b0;
    end else begin
      seed_ready <= 1'b1;
    end
  end

  // Rotor: rotate right by one each step, overwritten by a reseed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rotor <= SEED_W;
    end else if (seed_accept) begin
      rotor <= seed_i;
    end else if (gen_step) begin
      rotor <= {rotor[0], rotor[W-1:1]};
    end
  end

  // Output stage. A reseed drops rng_valid even when the current word is
  // being consumed in the same cycle; the consumer still owns that word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rng_o     <= SEED_W;
      rng_valid <= 1'b0;
    end else if (seed_accept) begin
      rng_valid <= 1'b0;
    end else if (load_word) begin
      rng_o     <= rotor ^ lfsr_value;
      rng_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Repetition health test
  // --------------------------------------------------------------------------
`ifdef RNG_HEALTH_EN
  localparam int             RCW   = (REP_LIMIT > 1) ? $clog2(REP_LIMIT + 1) : 1;
  localparam logic [RCW-1:0] REP_C = RCW'(REP_LIMIT);

  logic [RCW-1:0] rep_cnt;
  logic [RCW-1:0] rep_cnt_next;
  logic [W-1:0]   last_word;
  logic           health_flag;
  logic           word_taken;

  assign word_taken = rng_valid && rng_ready;

  // rep_cnt == 0 means no word accepted since reset/reseed; the first
  // accepted word starts a run of length 1.
  always_comb begin
    rep_cnt_next = rep_cnt;
    if (word_taken) begin
      if (rep_cnt != '0 && rng_o == last_word) begin
        rep_cnt_next = (rep_cnt == REP_C) ? rep_cnt : rep_cnt + RCW'(1);
      end else begin
        rep_cnt_next = RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || seed_accept) begin
      rep_cnt     <= '0;
      last_word   <= '0;
      health_flag <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt_next;
      if (word_taken) begin
        last_word <= rng_o;
      end
      if (rep_cnt_next == REP_C) begin
        health_flag <= 1'b1;
      end
    end
  end

  assign health_err = health_flag;
`else
  assign health_err = 1'b0;
`endif

endmodule
`default_nettype wire
